// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the RV32I subset core: sequences fetch, decode, execute,
// memory and write-back, and guards the shared memory port with a ready handshake and timeout.
module multicycle_controller #(
  parameter int OPCODE_W     = 7,
  parameter bit ENABLE_JUMPS = 1'b1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                MemReq,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                Branch,
  output logic                JalrSel,
  output logic [1:0]          ALUOp,
  output logic [1:0]          RWSel,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_LW, K_SW, K_BR, K_R, K_ADDI, K_LUI, K_JAL, K_JALR
  } kind_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  kind_t               kind_q, kind_in;

  function automatic kind_t classify(input logic [OPCODE_W-1:0] op);
    kind_t k;
    case (op)
      OP_LW:   k = K_LW;
      OP_SW:   k = K_SW;
      OP_BR:   k = K_BR;
      OP_R:    k = K_R;
      OP_ADDI: k = K_ADDI;
      OP_LUI:  k = K_LUI;
      OP_JAL:  k = K_JAL;
      OP_JALR: k = K_JALR;
      default: k = K_ILL;
    endcase
    if (!ENABLE_JUMPS && (k == K_JAL || k == K_JALR)) k = K_ILL;
    return k;
  endfunction

  assign kind_q  = classify(op_q);
  assign kind_in = classify(Opcode);
  assign state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = '0;
    MemReq   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    JalrSel  = 1'b0;
    ALUOp    = 2'b00;
    RWSel    = 2'b00;
    fault    = 1'b0;

    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      ALUSrc = !(kind_q inside {K_R, K_BR});
      case (kind_q)
        K_BR:          ALUOp = 2'b01;
        K_R, K_ADDI:   ALUOp = 2'b10;
        K_LUI, K_JAL:  ALUOp = 2'b11;
        default:       ALUOp = 2'b00;
      endcase
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = Opcode;
        state_d = (kind_in == K_ILL) ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        case (kind_q)
          K_BR: begin
            Branch  = 1'b1;
            state_d = S_FETCH;
          end
          K_JAL, K_JALR: begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
            JalrSel = (kind_q == K_JALR);
            state_d = S_WB;
          end
          K_LW, K_SW: state_d = S_MEM;
          K_ILL:      state_d = S_FAULT;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemRead  = (kind_q == K_LW);
        MemWrite = (kind_q == K_SW);
        if (mem_ready) state_d = (kind_q == K_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (kind_q == K_LW);
        RWSel    = (kind_q inside {K_JAL, K_JALR}) ? 2'b01 : 2'b00;
        state_d  = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase

    // Counter holds the number of completed wait cycles on the pending request;
    // the cycle that would make it reach MEM_TIMEOUT diverts to FAULT instead.
    if (MemReq && !mem_ready) begin
      if (state_d == state_q) wait_d = wait_q + WAIT_W'(1);
      if (MEM_TIMEOUT > 0 && wait_q == WAIT_W'(TO_LAST)) state_d = S_FAULT;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three parameterisations share stimulus; a per-instruction
// cycle model builds the expected output vector for every cycle.
module tb_multicycle_controller;

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_LUI} kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, mrd, mwr, irw, pcw, asrc;
    logic [1:0] aop;
    logic       br, jsel, rw, m2r;
    logic [1:0] rws;
    logic       flt;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic       rdy;
    logic [6:0] op;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = '0;
  logic       mem_ready = 1'b0;

  logic       mreq_w [3], mrd_w [3], mwr_w [3], irw_w [3], pcw_w [3], asrc_w [3];
  logic       m2r_w [3], rw_w [3], br_w [3], jsel_w [3], flt_w [3];
  logic [1:0] aop_w [3], rws_w [3];
  logic [2:0] st_w [3];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   sel      = 0;
  step_t q[$];

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: jumps disabled; 2: timeout disabled
  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_controller #(
      .OPCODE_W    (7),
      .ENABLE_JUMPS(g != 1),
      .MEM_TIMEOUT ((g == 2) ? 0 : 15)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .Opcode   (Opcode),
      .mem_ready(mem_ready),
      .MemReq   (mreq_w[g]),
      .MemRead  (mrd_w[g]),
      .MemWrite (mwr_w[g]),
      .IRWrite  (irw_w[g]),
      .PCWrite  (pcw_w[g]),
      .ALUSrc   (asrc_w[g]),
      .MemtoReg (m2r_w[g]),
      .RegWrite (rw_w[g]),
      .Branch   (br_w[g]),
      .JalrSel  (jsel_w[g]),
      .ALUOp    (aop_w[g]),
      .RWSel    (rws_w[g]),
      .fault    (flt_w[g]),
      .state    (st_w[g])
    );
  end

  function automatic vec_t obs_of(input int s);
    vec_t v;
    v.st = st_w[s];   v.mreq = mreq_w[s]; v.mrd = mrd_w[s];   v.mwr = mwr_w[s];
    v.irw = irw_w[s]; v.pcw = pcw_w[s];   v.asrc = asrc_w[s]; v.aop = aop_w[s];
    v.br = br_w[s];   v.jsel = jsel_w[s]; v.rw = rw_w[s];     v.m2r = m2r_w[s];
    v.rws = rws_w[s]; v.flt = flt_w[s];
    return v;
  endfunction

  function automatic logic [6:0] op_of(input kind_t k);
    case (k)
      K_R:    return 7'b0110011;
      K_ADDI: return 7'b0010011;
      K_LW:   return 7'b0000011;
      K_SW:   return 7'b0100011;
      K_BR:   return 7'b1100011;
      K_JAL:  return 7'b1101111;
      K_JALR: return 7'b1100111;
      default: return 7'b0110111;
    endcase
  endfunction

  function automatic logic [1:0] aop_of(input kind_t k);
    case (k)
      K_BR:          return 2'b01;
      K_R, K_ADDI:   return 2'b10;
      K_LUI, K_JAL:  return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

  // A cycle in the given state with everything else idle; don't-care inputs are randomised.
  function automatic step_t mk(input logic [2:0] st);
    step_t s;
    s.v    = '0;
    s.v.st = st;
    s.rdy  = 1'($urandom);
    s.op   = 7'($urandom);
    return s;
  endfunction

  function automatic step_t fetch_wait();
    step_t s;
    s = mk(3'd1);
    s.v.mreq = 1'b1;
    s.v.mrd  = 1'b1;
    s.rdy    = 1'b0;
    return s;
  endfunction

  task automatic push_fetch(input int fw);
    step_t s;
    for (int i = 0; i < fw; i++) q.push_back(fetch_wait());
    s = fetch_wait();
    s.rdy = 1'b1; s.v.irw = 1'b1; s.v.pcw = 1'b1;
    q.push_back(s);
  endtask

  task automatic push_instr(input kind_t k, input int fw, input int mw);
    step_t s;
    logic  asrc;
    asrc = !(k == K_R || k == K_BR);
    push_fetch(fw);
    s = mk(3'd2); s.op = op_of(k); q.push_back(s);
    s = mk(3'd3); s.v.asrc = asrc; s.v.aop = aop_of(k);
    s.v.br   = (k == K_BR || k == K_JAL || k == K_JALR);
    s.v.pcw  = (k == K_JAL || k == K_JALR);
    s.v.jsel = (k == K_JALR);
    q.push_back(s);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        s = mk(3'd4); s.v.asrc = asrc; s.v.aop = aop_of(k);
        s.v.mreq = 1'b1; s.v.mrd = (k == K_LW); s.v.mwr = (k == K_SW);
        s.rdy = (i == mw);
        q.push_back(s);
      end
    end
    if (k != K_BR && k != K_SW) begin
      s = mk(3'd5); s.v.asrc = asrc; s.v.aop = aop_of(k);
      s.v.rw = 1'b1; s.v.m2r = (k == K_LW);
      s.v.rws = (k == K_JAL || k == K_JALR) ? 2'b01 : 2'b00;
      q.push_back(s);
    end
  endtask

  task automatic push_fault(input logic [6:0] op, input int nf);
    step_t s;
    push_fetch(0);
    s = mk(3'd2); s.op = op; q.push_back(s);
    for (int i = 0; i < nf; i++) begin
      s = mk(3'd7); s.v.flt = 1'b1; q.push_back(s);
    end
  endtask

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; applies each step's inputs, checks just after, moves to the next negedge.
  task automatic run(input string tag);
    step_t s;
    int    i;
    i = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      Opcode    = s.op;
      mem_ready = s.rdy;
      #1;
      check($sformatf("%s[%0d]", tag, i), obs_of(sel), s.v);
      i++;
      @(negedge clk);
    end
  endtask

  // Entered at a negedge; leaves at the next negedge with reset just released.
  task automatic do_reset(input string tag);
    reset     = 1'b1;
    mem_ready = 1'b1;
    Opcode    = 7'($urandom);
    #1;
    for (int g = 0; g < 3; g++) check($sformatf("%s_rst%0d", tag, g), obs_of(g), vec_t'(0));
    @(negedge clk);
    reset = 1'b0;
    q.push_back(mk(3'd0));
  endtask

  initial begin
    step_t m;
    @(negedge clk);

    // Directed sequence on the default instance
    sel = 0;
    do_reset("dir");
    push_instr(K_R, 0, 0);
    push_instr(K_LW, 0, 3);
    push_instr(K_JAL, 0, 0);
    push_instr(K_JALR, 1, 0);
    push_instr(K_BR, 0, 0);
    push_instr(K_SW, 2, 1);
    push_instr(K_ADDI, 0, 0);
    push_instr(K_LUI, 0, 0);
    q.push_back(fetch_wait());
    run("dir");

    // Randomised instruction stream with random memory latency
    do_reset("rnd");
    for (int i = 0; i < 40; i++)
      push_instr(kind_t'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3));
    run("rnd");

    // Illegal opcode is sticky until reset
    do_reset("ill");
    push_fault(7'b1111111, 6);
    run("ill");
    do_reset("ill_clr");
    push_instr(K_ADDI, 0, 0);
    run("ill_clr");

    // Jumps disabled: JAL and JALR both fault after DECODE
    sel = 1;
    do_reset("nj_jal");
    push_instr(K_R, 0, 0);
    push_fault(op_of(K_JAL), 3);
    run("nj_jal");
    do_reset("nj_jalr");
    push_fault(op_of(K_JALR), 3);
    run("nj_jalr");

    // Fetch timeout: exactly 15 waiting cycles, then FAULT
    sel = 0;
    do_reset("to");
    for (int i = 0; i < 15; i++) q.push_back(fetch_wait());
    for (int i = 0; i < 3; i++) begin
      m = mk(3'd7); m.v.flt = 1'b1; m.rdy = 1'b0; q.push_back(m);
    end
    run("to");

    // Timeout disabled: 100 waiting cycles then a normal instruction
    sel = 2;
    do_reset("nto");
    for (int i = 0; i < 100; i++) q.push_back(fetch_wait());
    push_instr(K_LW, 0, 20);
    q.push_back(fetch_wait());
    run("nto");

    // Asynchronous reset in the middle of an SW memory wait
    sel = 0;
    do_reset("swr");
    push_instr(K_SW, 0, 1);
    m = q.pop_back();
    run("swr");
    mem_ready = 1'b0;
    #1;
    m.rdy = 1'b0;
    check("swr_mem", obs_of(0), m.v);
    #2;
    reset = 1'b1;
    #1;
    check("swr_async", obs_of(0), vec_t'(0));
    @(negedge clk);
    reset = 1'b0;
    q.push_back(mk(3'd0));
    push_instr(K_R, 0, 0);
    q.push_back(fetch_wait());
    run("swr_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control unit for the RV32I subset core (R-type, addi, lw, sw, beq/bne/blt/bge, jal, jalr, lui). It replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It drives a shared instruction/data memory port through a ready handshake with timeout. It sits between the instruction register (IR), the datapath muxes and the memory interface.

## Interface
- OPCODE_W, 7, opcode field width
- ENABLE_JUMPS, 1, when 0 JAL/JALR decode as illegal
- MEM_TIMEOUT, 15, max wait cycles on a memory request before fault; 0 disables timeout
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Opcode  in  OPCODE_W  opcode from IR, sampled only in DECODE
- mem_ready  in  1  memory completes current request this cycle
- MemReq  out  1  memory request valid
- MemRead  out  1  read request (fetch or lw)
- MemWrite  out  1  write request (sw)
- IRWrite  out  1  load IR from memory read data
- PCWrite  out  1  write PC (PC+4 on fetch, target on jal/jalr)
- ALUSrc, MemtoReg, RegWrite, Branch, JalrSel  out  1 each  same meaning as existing datapath controls
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 pass/PC-relative
- RWSel  out  2  bit0 = write PC+4 to rd; bit1 always 0
- fault  out  1  sticky illegal-opcode / memory-timeout flag
- state  out  3  current state encoding, debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Encoding 6 is unreachable and must go to FAULT.
- IDLE: all outputs 0. Goes to FETCH next cycle unconditionally.
- FETCH: MemReq=1, MemRead=1.
  - mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: Opcode is latched into op_q.
  - Illegal opcode (not in the table, or JAL/JALR with ENABLE_JUMPS=0): go to FAULT.
  - Otherwise go to EXEC.
- Decode table for op_q:
  - LW/SW: ALUSrc=1, ALUOp=00.
  - BR: ALUSrc=0, ALUOp=01.
  - R-type: ALUSrc=0, ALUOp=10.
  - addi: ALUSrc=1, ALUOp=10.
  - LUI/JAL: ALUSrc=1, ALUOp=11.
  - JALR: ALUSrc=1, ALUOp=00.
- ALUSrc/ALUOp are driven from op_q in EXEC, MEM and WB, and are 0 in all other states.
- EXEC transitions:
  - BR: Branch=1 for one cycle, then go to FETCH. The datapath gates Branch with the compare result.
  - JAL: Branch=1, PCWrite=1, then go to WB.
  - JALR: Branch=1, JalrSel=1, PCWrite=1, then go to WB.
  - LW/SW: go to MEM.
  - R-type/addi/LUI: go to WB.
- MEM: MemReq=1, with MemRead=1 for LW or MemWrite=1 for SW. Hold until mem_ready=1, then LW goes to WB and SW goes to FETCH.
- WB: RegWrite=1 for one cycle, then go to FETCH.
  - MemtoReg=1 for LW.
  - RWSel=01 for JAL/JALR, 00 otherwise.
- Wait counter (width clog2(MEM_TIMEOUT+1)):
  - Cleared on entry to FETCH/MEM and whenever mem_ready=1.
  - Increments each cycle with MemReq=1 and mem_ready=0.
  - Reaching MEM_TIMEOUT forces FAULT on the next edge, even if the request is still pending.
- FAULT: all outputs 0 except fault=1. Stays until reset.

## Timing
- Reset values: state=IDLE, op_q=0, wait counter=0, fault=0. Every other output is 0 while reset is high and in the cycle after release.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous). Any pending MemReq drops in the same delta. No write strobe (RegWrite, MemWrite, PCWrite, IRWrite) may glitch high.
- IRWrite/PCWrite in FETCH and state exits from FETCH/MEM are Mealy on mem_ready. All other outputs are Moore on state and op_q.
- Cycles per instruction with zero-wait memory (mem_ready=1 on the first request cycle):
  - BR: 3.
  - SW, R-type, addi, LUI, JAL, JALR: 4.
  - LW: 5.
  - Each wait cycle adds 1 per memory access.
- First FETCH occurs 2 edges after reset release.
- Opcode changes outside DECODE have no effect.
- mem_ready high outside FETCH/MEM is ignored.

## Test plan
- Reset release, then R-type 0110011 with mem_ready tied 1 → state sequence 0,1,2,3,5,1. RegWrite=1 only in WB. Next IRWrite occurs 4 cycles after the first.
- LW 0000011 with mem_ready low for 3 cycles in MEM → MemReq/MemRead held 4 cycles, then WB with MemtoReg=1 and RegWrite=1. Total 8 cycles.
- JAL 1101111 → in EXEC: Branch=1, PCWrite=1, ALUOp=11. In WB: RWSel=01. With ENABLE_JUMPS=0 the same opcode leads to FAULT after DECODE, with fault=1 and all strobes 0.
- Illegal opcode 1111111 → DECODE→FAULT. Stays in FAULT ignoring mem_ready. Reset returns state to 0 and fault to 0.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → FAULT entered after exactly 15 waiting cycles. With MEM_TIMEOUT=0 it waits 100 cycles without fault.
- Reset asserted mid-MEM during SW → MemWrite drops to 0 asynchronously and state=0. Re-fetch starts 2 edges after release.
